// File: rtl/hazard_control.sv
// Pipeline hazard unit: detects load-use and redirect hazards, freezes on a busy data
// memory, and drives the pipeline enables/flushes combinationally with event counters.
module hazard_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_ID,
  input  logic [31:0] instruction_EX,
  input  logic        MemRead_EX,
  input  logic        BranchTaken_EX,
  input  logic        Jump_EX,
  input  logic        mem_busy_MEM,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic [1:0]  hazard_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FREEZE     = 2'b10
  } hazardState_e;

  hazardState_e stateQ, stateNext;

  logic [4:0] rsId, rtId, rtEx;
  logic       loadUse, redirect;
  logic       doStall, doFlush;
  logic       unusedBits;

  assign rsId = instruction_ID[25:21];
  assign rtId = instruction_ID[20:16];
  assign rtEx = instruction_EX[20:16];

  // Opcode/immediate fields are not needed for hazard detection.
  assign unusedBits = ^{instruction_ID[31:26], instruction_ID[15:0],
                        instruction_EX[31:21], instruction_EX[15:0]};

  // $zero is never a real producer, so rt_EX == 0 cannot create a dependency.
  assign loadUse  = MemRead_EX && (rtEx != 5'd0) && ((rtEx == rsId) || (rtEx == rtId));
  assign redirect = BranchTaken_EX || Jump_EX;

  assign doFlush = !reset && !mem_busy_MEM && redirect;
  assign doStall = !reset && !mem_busy_MEM && !redirect && loadUse;

  // Outputs are Mealy: they follow the current inputs with priority
  // reset > mem busy > redirect > load-use > normal.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    stateNext    = RUN;

    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (mem_busy_MEM) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      stateNext    = FREEZE;
    end else if (redirect) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (loadUse) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      stateNext    = LOAD_STALL;
    end
  end

  // NOTE: state and counters use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= RUN;
      stall_count <= 16'h0000;
      flush_count <= 16'h0000;
    end else begin
      stateQ <= stateNext;
      if (doStall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (doFlush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end

  assign hazard_state = stateQ;

endmodule

// File: tb/tb_hazard_control.sv
// Directed-vector bench for hazard_control: combinational outputs checked mid-cycle,
// state and counters checked just after each rising edge.
module tb_hazard_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_ID, instruction_EX;
  logic        MemRead_EX, BranchTaken_EX, Jump_EX, mem_busy_MEM;
  logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Bubble;
  logic [1:0]  hazard_state;
  logic [15:0] stall_count, flush_count;

  int nCompared   = 0;
  int nMismatched = 0;

  // Output vector order: {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Bubble}
  localparam logic [5:0] OUT_RESET = 6'b000011;
  localparam logic [5:0] OUT_RUN   = 6'b111100;
  localparam logic [5:0] OUT_STALL = 6'b001101;
  localparam logic [5:0] OUT_FLUSH = 6'b111111;
  localparam logic [5:0] OUT_FRZ   = 6'b000000;

  hazard_control dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_ID (instruction_ID),
    .instruction_EX (instruction_EX),
    .MemRead_EX     (MemRead_EX),
    .BranchTaken_EX (BranchTaken_EX),
    .Jump_EX        (Jump_EX),
    .mem_busy_MEM   (mem_busy_MEM),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Write    (ID_EX_Write),
    .EX_MEM_Write   (EX_MEM_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .hazard_state   (hazard_state),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkInstr(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] rsId, input logic [4:0] rtId,
                       input logic [4:0] rtEx, input logic memRd, input logic br,
                       input logic jmp, input logic busy);
    reset          = rst;
    instruction_ID = mkInstr(rsId, rtId);
    instruction_EX = mkInstr(5'd7, rtEx);
    MemRead_EX     = memRd;
    BranchTaken_EX = br;
    Jump_EX        = jmp;
    mem_busy_MEM   = busy;
  endtask

  // Checks outputs mid-cycle, clocks once, then checks registered state and counters.
  task automatic step(input string tag, input logic [5:0] expOut, input logic [1:0] expState,
                      input logic [15:0] expStall, input logic [15:0] expFlush);
    @(negedge clk);
    check({tag, ".out"}, {26'd0, PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                          IF_ID_Flush, ID_EX_Bubble}, {26'd0, expOut});
    @(posedge clk);
    #1;
    check({tag, ".state"}, {30'd0, hazard_state}, {30'd0, expState});
    check({tag, ".stall"}, {16'd0, stall_count},  {16'd0, expStall});
    check({tag, ".flush"}, {16'd0, flush_count},  {16'd0, expFlush});
  endtask

  initial begin
    drive(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    // Reset overrides a busy memory, a jump and a load-use at once.
    step("reset",        OUT_RESET, 2'b00, 16'd0, 16'd0);
    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle",         OUT_RUN,   2'b00, 16'd0, 16'd0);
    // lw $8 in EX, add rs=8 in ID
    drive(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs",        OUT_STALL, 2'b01, 16'd1, 16'd0);
    drive(1'b0, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stall_end",    OUT_RUN,   2'b00, 16'd1, 16'd0);
    drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_zero",      OUT_RUN,   2'b00, 16'd1, 16'd0);
    drive(1'b0, 5'd2, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rt",        OUT_STALL, 2'b01, 16'd2, 16'd0);
    step("lu_b2b",       OUT_STALL, 2'b01, 16'd3, 16'd0);
    drive(1'b0, 5'd2, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_nomatch",   OUT_RUN,   2'b00, 16'd3, 16'd0);
    // Taken branch wins over a simultaneous load-use.
    drive(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_over_lu",   OUT_FLUSH, 2'b00, 16'd3, 16'd1);
    // Three busy cycles with a jump and a load-use pending: full freeze, no counting.
    drive(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    step("frz1",         OUT_FRZ,   2'b10, 16'd3, 16'd1);
    step("frz2",         OUT_FRZ,   2'b10, 16'd3, 16'd1);
    step("frz3",         OUT_FRZ,   2'b10, 16'd3, 16'd1);
    drive(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    step("frz_release",  OUT_FLUSH, 2'b00, 16'd3, 16'd2);
    // Release straight into a load-use re-evaluates in the same cycle.
    drive(1'b0, 5'd6, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step("frz_lu",       OUT_FRZ,   2'b10, 16'd3, 16'd2);
    drive(1'b0, 5'd6, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rel_lu",       OUT_STALL, 2'b01, 16'd4, 16'd2);
    // Reset mid-FREEZE aborts to RUN and clears counters.
    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step("frz_pre_rst",  OUT_FRZ,   2'b10, 16'd4, 16'd2);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rst_in_frz",   OUT_RESET, 2'b00, 16'd0, 16'd0);
    step("rst_hold",     OUT_RESET, 2'b00, 16'd0, 16'd0);
    // First cycle after release follows normal priority from RUN.
    drive(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post_rst_lu",  OUT_STALL, 2'b01, 16'd1, 16'd0);
    // Drive the stall counter up to 16'hFFFE, then three more stalls saturate it.
    repeat (65533) @(posedge clk);
    #1;
    check("stall_fffe", {16'd0, stall_count}, 32'h0000_FFFE);
    step("sat1",         OUT_STALL, 2'b01, 16'hFFFF, 16'd0);
    step("sat2",         OUT_STALL, 2'b01, 16'hFFFF, 16'd0);
    step("sat3",         OUT_STALL, 2'b01, 16'hFFFF, 16'd0);
    drive(1'b0, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    step("jump_after",   OUT_FLUSH, 2'b00, 16'hFFFF, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
